// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the hazard/stall sequencer.
// Used by hazard_scoreboard and hazard_ctrl (HAZARD_FWD_EN selects forwarding).
package hazard_pkg;

  localparam int MAX_MEM_DELAY = 7;
  localparam int RD_MAX_W = 8;

  function automatic int avail_w(input int mem_delay);
    return $clog2(mem_delay + 2);
  endfunction

  localparam int AV_MAX_W = avail_w(MAX_MEM_DELAY);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_HAZ = 2'd1,
    ST_FRZ = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic [AV_MAX_W-1:0] avail;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight writer slots EX..WB with result countdowns.
// HAZARD_FWD_EN: blocking decided by avail; otherwise by slot position.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int MEM_DELAY  = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  ins_valid,
  input  logic                  ins_load,
  input  logic [REG_ADDR_W-1:0] ins_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  output logic [PIPE_DEPTH-1:0] rs1_hit,
  output logic [PIPE_DEPTH-1:0] rs2_hit,
  output logic [PIPE_DEPTH-1:0] blk_alu,
  output logic [PIPE_DEPTH-1:0] blk_br
);

  localparam logic [AV_MAX_W-1:0] AV_ALU = AV_MAX_W'(1);
  localparam logic [AV_MAX_W-1:0] AV_LD  = AV_MAX_W'(MEM_DELAY + 1);

  sb_entry_t sb [PIPE_DEPTH];
  sb_entry_t ins_e;

  function automatic sb_entry_t aged(input sb_entry_t e);
    aged = e;
    if (e.avail != '0)
      aged.avail = e.avail - AV_MAX_W'(1);
  endfunction

  // Entry presented by decode for insertion into slot 0
  always_comb begin
    ins_e.valid = ins_valid;
    ins_e.rd    = RD_MAX_W'(ins_rd);
    ins_e.avail = ins_load ? AV_LD : AV_ALU;
  end

  // Slot shift register; countdowns age as entries move
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++)
        sb[i] <= '0;
    end else if (!hold) begin
      sb[0] <= ins_e;
      for (int i = 1; i < PIPE_DEPTH; i++)
        sb[i] <= aged(sb[i-1]);
    end
  end

  // Per-slot source matches and per-slot blocking qualifiers
  always_comb begin
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      rs1_hit[i] = rs1_used && (rs1 != '0) && sb[i].valid
                   && (RD_MAX_W'(rs1) == sb[i].rd);
      rs2_hit[i] = rs2_used && (rs2 != '0) && sb[i].valid
                   && (RD_MAX_W'(rs2) == sb[i].rd);
`ifdef HAZARD_FWD_EN
      blk_alu[i] = sb[i].avail >= AV_MAX_W'(2);
      blk_br[i]  = sb[i].avail != '0;
`else
      blk_alu[i] = (i < PIPE_DEPTH - 1);
      blk_br[i]  = (i < PIPE_DEPTH - 1);
`endif
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard detection, stall/flush sequencing, freeze handling.
// Build with HAZARD_FWD_EN when the forwarding network is present.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int MEM_DELAY  = 1,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  id_is_branch,
  input  logic                  flush,
  input  logic                  ext_stall,
  output logic                  pc_en,
  output logic                  fd_en,
  output logic                  de_bubble,
  output logic                  fd_flush,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PIPE_DEPTH-1:0] rs1_hit, rs2_hit;
  logic [PIPE_DEPTH-1:0] blk_alu, blk_br, blk;
  logic hazard, flush_eff, flush_pend, ins_valid;
  hz_state_t state, state_nx, ret_st, ret_nx;

  assign flush_eff = flush | flush_pend;
  assign ins_valid = id_valid & id_rd_we & (id_rd != '0)
                     & ~hazard & ~flush_eff;
  assign state_o   = state;

  hazard_scoreboard #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .MEM_DELAY  (MEM_DELAY),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .hold      (ext_stall),
    .ins_valid (ins_valid),
    .ins_load  (id_is_load),
    .ins_rd    (id_rd),
    .rs1       (id_rs1),
    .rs2       (id_rs2),
    .rs1_used  (id_rs1_used),
    .rs2_used  (id_rs2_used),
    .rs1_hit   (rs1_hit),
    .rs2_hit   (rs2_hit),
    .blk_alu   (blk_alu),
    .blk_br    (blk_br)
  );

  // Branches compare in ID, so they block on a stricter qualifier
  always_comb begin
    blk    = id_is_branch ? blk_br : blk_alu;
    hazard = id_valid && |((rs1_hit | rs2_hit) & blk);
  end

  // Pipeline enables by priority: reset, freeze, flush, hazard
  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    de_bubble = 1'b0;
    fd_flush  = 1'b0;
    if (rst) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_bubble = 1'b1;
    end else if (ext_stall) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
    end else if (flush_eff) begin
      de_bubble = 1'b1;
      fd_flush  = 1'b1;
    end else if (hazard) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_bubble = 1'b1;
    end
  end

  // Remember a mispredict that lands while the pipe is frozen
  always_ff @(posedge clk) begin
    if (rst)
      flush_pend <= 1'b0;
    else if (ext_stall)
      flush_pend <= flush_pend | flush;
    else
      flush_pend <= 1'b0;
  end

  // Saturating count of real hazard-stall cycles
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (!ext_stall && !flush_eff && hazard && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  // State register plus the state to resume after a freeze
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      ret_st <= ST_RUN;
    end else begin
      state  <= state_nx;
      ret_st <= ret_nx;
    end
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    ret_nx   = ret_st;
    unique case (state)
      ST_RUN: begin
        if (ext_stall) begin
          state_nx = ST_FRZ;
          ret_nx   = ST_RUN;
        end else if (hazard && !flush_eff) begin
          state_nx = ST_HAZ;
        end
      end
      ST_HAZ: begin
        if (ext_stall) begin
          state_nx = ST_FRZ;
          ret_nx   = ST_HAZ;
        end else if (flush_eff || !hazard) begin
          state_nx = ST_RUN;
        end
      end
      ST_FRZ: begin
        if (!ext_stall)
          state_nx = ret_st;
      end
      default: state_nx = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two hazard_ctrl configurations driven in lockstep,
// checked every cycle against a ready-time model plus directed literals.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, id_valid, rs1u, rs2u, we, ld, br, flush, ext_stall;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic pc_en [2];
  logic fd_en [2];
  logic de_bubble [2];
  logic fd_flush [2];
  logic [1:0] st [2];
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int vec_n = 0;
  int err_n = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .PIPE_DEPTH(3), .MEM_DELAY(1), .REG_ADDR_W(5), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(rs1u), .id_rs2_used(rs2u),
    .id_rd(id_rd), .id_rd_we(we),
    .id_is_load(ld), .id_is_branch(br),
    .flush(flush), .ext_stall(ext_stall),
    .pc_en(pc_en[0]), .fd_en(fd_en[0]),
    .de_bubble(de_bubble[0]), .fd_flush(fd_flush[0]),
    .state_o(st[0]), .stall_cnt(cnt_a)
  );

  hazard_ctrl #(
    .PIPE_DEPTH(5), .MEM_DELAY(2), .REG_ADDR_W(5), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(rs1u), .id_rs2_used(rs2u),
    .id_rd(id_rd), .id_rd_we(we),
    .id_is_load(ld), .id_is_branch(br),
    .flush(flush), .ext_stall(ext_stall),
    .pc_en(pc_en[1]), .fd_en(fd_en[1]),
    .de_bubble(de_bubble[1]), .fd_flush(fd_flush[1]),
    .state_o(st[1]), .stall_cnt(cnt_b)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vec_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  function automatic int pd_of(input int d);
    return (d == 0) ? 3 : 5;
  endfunction
  function automatic int md_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction
  function automatic int cmax_of(input int d);
    return (d == 0) ? 65535 : 15;
  endfunction

  // Model: issued writers with the cycle they issued and result latency
  int m_n = 0;
  bit m_v [2][16];
  int m_t [2][16];
  int m_rd [2][16];
  int m_lat [2][16];
  int m_wp [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  bit m_lfz [2] = '{1'b0, 1'b0};
  bit m_lst [2] = '{1'b0, 1'b0};
  bit m_fp = 1'b0;

  function automatic bit m_haz(input int d);
    bit h;
    h = 1'b0;
    if (!id_valid) return 1'b0;
    for (int k = 0; k < 16; k++) begin
      int age;
      bit mt;
      age = m_n - m_t[d][k];
      mt = (rs1u && id_rs1 == m_rd[d][k]) || (rs2u && id_rs2 == m_rd[d][k]);
      if (m_v[d][k] && m_rd[d][k] != 0 && mt
          && age >= 1 && age <= pd_of(d)) begin
        if (FWD) begin
          if (br ? (m_n <= m_t[d][k] + m_lat[d][k])
                 : (m_n <  m_t[d][k] + m_lat[d][k]))
            h = 1'b1;
        end else if (age <= pd_of(d) - 1) begin
          h = 1'b1;
        end
      end
    end
    return h;
  endfunction

  // Per-cycle compare against the model, then model update at the edge
  initial begin : cmp
    bit hz [2];
    bit fe;
    bit e_pc, e_bub, e_ffl;
    int e_st;
    forever begin
      @(negedge clk);
      fe = flush | m_fp;
      for (int d = 0; d < 2; d++) begin
        hz[d] = m_haz(d);
        if (rst) begin
          e_pc = 0; e_bub = 1; e_ffl = 0;
        end else if (ext_stall) begin
          e_pc = 0; e_bub = 0; e_ffl = 0;
        end else if (fe) begin
          e_pc = 1; e_bub = 1; e_ffl = 1;
        end else if (hz[d]) begin
          e_pc = 0; e_bub = 1; e_ffl = 0;
        end else begin
          e_pc = 1; e_bub = 0; e_ffl = 0;
        end
        e_st = m_lfz[d] ? 2 : (m_lst[d] ? 1 : 0);
        chk($sformatf("pc_en[%0d]", d), pc_en[d], e_pc);
        chk($sformatf("fd_en[%0d]", d), fd_en[d], e_pc);
        chk($sformatf("de_bubble[%0d]", d), de_bubble[d], e_bub);
        chk($sformatf("fd_flush[%0d]", d), fd_flush[d], e_ffl);
        chk($sformatf("state_o[%0d]", d), st[d], e_st);
        chk($sformatf("stall_cnt[%0d]", d),
            (d == 0) ? 32'(cnt_a) : 32'(cnt_b), m_cnt[d]);
      end
      @(posedge clk);
      if (rst) begin
        m_n = 0;
        m_fp = 0;
        for (int d = 0; d < 2; d++) begin
          for (int k = 0; k < 16; k++) m_v[d][k] = 0;
          m_cnt[d] = 0; m_lfz[d] = 0; m_lst[d] = 0;
        end
      end else if (ext_stall) begin
        if (flush) m_fp = 1;
        for (int d = 0; d < 2; d++) m_lfz[d] = 1;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (m_lfz[d]) m_lfz[d] = 0;
          else m_lst[d] = hz[d] & ~fe;
          if (hz[d] && !fe && m_cnt[d] < cmax_of(d)) m_cnt[d]++;
          if (id_valid && we && id_rd != 0 && !hz[d] && !fe) begin
            m_v[d][m_wp[d]] = 1;
            m_t[d][m_wp[d]] = m_n;
            m_rd[d][m_wp[d]] = id_rd;
            m_lat[d][m_wp[d]] = ld ? 1 + md_of(d) : 1;
            m_wp[d] = (m_wp[d] + 1) % 16;
          end
        end
        m_fp = 0;
        m_n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input bit v, input int r1, input bit u1,
                       input int r2, input bit u2, input int rd,
                       input bit w, input bit l, input bit b);
    id_valid = v;
    id_rs1 = 5'(r1); rs1u = u1;
    id_rs2 = 5'(r2); rs2u = u2;
    id_rd = 5'(rd); we = w; ld = l; br = b;
  endtask

  task automatic nop(input int n);
    set_i(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic run(input int hold, output int sa, output int sb,
                     output int hs);
    sa = 0; sb = 0; hs = 0;
    repeat (hold) begin
      @(negedge clk);
      if (!pc_en[0]) sa++;
      if (!pc_en[1]) sb++;
      if (st[1] == 2'd1) hs++;
      tick();
    end
  endtask

  initial begin : main
    int sa, sb, hs;
    rst = 1; flush = 0; ext_stall = 0;
    set_i(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    chk("rst_pc_en", pc_en[0], 0);
    chk("rst_bubble", de_bubble[0], 1);
    chk("rst_fd_flush", fd_flush[0], 0);
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("post_rst_cnt", cnt_a, 0);
    chk("post_rst_state", st[0], 0);
    chk("post_rst_pc_en", pc_en[0], 1);
    tick();

    // load x5 ; add x6,x5,x1
    set_i(1, 0, 0, 0, 0, 5, 1, 1, 0); run(1, sa, sb, hs);
    set_i(1, 5, 1, 1, 1, 6, 1, 0, 0); run(6, sa, sb, hs);
    chk("ld_alu_stall_a", sa, FWD ? 1 : 2);
    chk("ld_alu_stall_b", sb, FWD ? 2 : 4);
    nop(8);
    chk("ld_alu_cnt_a", cnt_a, FWD ? 1 : 2);
    chk("ld_alu_cnt_b", cnt_b, FWD ? 2 : 4);

    // load x5 ; beq x5,x0
    set_i(1, 0, 0, 0, 0, 5, 1, 1, 0); run(1, sa, sb, hs);
    set_i(1, 5, 1, 0, 1, 0, 0, 0, 1); run(7, sa, sb, hs);
    chk("ld_br_stall_a", sa, 2);
    chk("ld_br_stall_b", sb, FWD ? 3 : 4);
    chk("ld_br_haz_state_b", hs, FWD ? 3 : 4);
    nop(8);
    chk("ld_br_state_end_b", st[1], 0);

    // addi x7 ; bne x7,x2
    set_i(1, 1, 1, 0, 0, 7, 1, 0, 0); run(1, sa, sb, hs);
    set_i(1, 7, 1, 2, 1, 0, 0, 0, 1); run(6, sa, sb, hs);
    chk("alu_br_stall_a", sa, FWD ? 1 : 2);
    chk("alu_br_stall_b", sb, FWD ? 1 : 4);
    nop(8);

    // addi x0 ; bne x0,x2
    set_i(1, 1, 1, 0, 0, 0, 1, 0, 0); run(1, sa, sb, hs);
    set_i(1, 0, 1, 2, 1, 0, 0, 0, 1); run(6, sa, sb, hs);
    chk("x0_stall_a", sa, 0);
    chk("x0_stall_b", sb, 0);
    nop(8);

    // add x3 ; sub x4,x3,x3
    set_i(1, 1, 1, 2, 1, 3, 1, 0, 0); run(1, sa, sb, hs);
    set_i(1, 3, 1, 3, 1, 4, 1, 0, 0); run(6, sa, sb, hs);
    chk("alu_alu_stall_a", sa, FWD ? 0 : 2);
    chk("alu_alu_stall_b", sb, FWD ? 0 : 4);
    nop(8);

    // freeze during load-use stall, mispredict lands mid-freeze
    set_i(1, 0, 0, 0, 0, 5, 1, 1, 0); run(1, sa, sb, hs);
    set_i(1, 5, 1, 1, 1, 6, 1, 0, 0);
    @(negedge clk);
    chk("frz_pre_pc_en_a", pc_en[0], 0);
    chk("frz_pre_bubble_b", de_bubble[1], 1);
    tick();
    ext_stall = 1;
    for (int i = 0; i < 4; i++) begin
      flush = (i == 1);
      @(negedge clk);
      chk("frz_pc_en_a", pc_en[0], 0);
      chk("frz_bubble_a", de_bubble[0], 0);
      chk("frz_fd_flush_b", fd_flush[1], 0);
      chk("frz_cnt_a", cnt_a, FWD ? 5 : 9);
      tick();
    end
    ext_stall = 0; flush = 0;
    @(negedge clk);
    chk("rel_fd_flush_a", fd_flush[0], 1);
    chk("rel_fd_flush_b", fd_flush[1], 1);
    chk("rel_pc_en_a", pc_en[0], 1);
    chk("rel_bubble_a", de_bubble[0], 1);
    tick();
    set_i(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rel2_fd_flush_a", fd_flush[0], 0);
    chk("rel2_pc_en_a", pc_en[0], 1);
    chk("rel2_cnt_a", cnt_a, FWD ? 5 : 9);
    tick();
    nop(8);

    // drive the counter to 0x00FF, then reset mid-stall
    rst = 1; tick(); tick(); rst = 0;
    for (int p = 0; p < 127; p++) begin
      set_i(1, 0, 0, 0, 0, 5, 1, 1, 0); run(1, sa, sb, hs);
      set_i(1, 5, 1, 0, 1, 0, 0, 0, 1); run(3, sa, sb, hs);
    end
    chk("pre_sat_cnt_a", cnt_a, 254);
    set_i(1, 0, 0, 0, 0, 5, 1, 1, 0); run(1, sa, sb, hs);
    set_i(1, 5, 1, 0, 1, 0, 0, 0, 1);
    tick();
    @(negedge clk);
    chk("cnt_ff_a", cnt_a, 16'h00FF);
    chk("cnt_sat_b", cnt_b, 15);
    chk("mid_stall_pc_en_a", pc_en[0], 0);
    tick();
    rst = 1;
    @(negedge clk);
    chk("mid_rst_pc_en_a", pc_en[0], 0);
    chk("mid_rst_bubble_a", de_bubble[0], 1);
    tick();
    rst = 0;
    @(negedge clk);
    chk("after_rst_cnt_a", cnt_a, 0);
    chk("after_rst_cnt_b", cnt_b, 0);
    chk("after_rst_pc_en_a", pc_en[0], 1);
    chk("after_rst_pc_en_b", pc_en[1], 1);
    chk("after_rst_bubble_a", de_bubble[0], 0);
    tick();
    nop(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
